// File: rtl/matrix_transpose_seq.sv
// Sequential R x C -> C x R transposer of 32-bit words, one word moved per clock.
// The result is published to A_T all at once, so the output never shows a partial transpose.
module matrix_transpose_seq #(
    parameter int ROWS = 1,
    parameter int COLS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [32*ROWS*COLS-1:0]   A,
    output logic [32*ROWS*COLS-1:0]   A_T,
    output logic                      busy,
    output logic                      done
);
    localparam int N    = ROWS * COLS;
    localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int CW   = $clog2(MAXD) + 1;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] R_LAST = CW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, COPY, FINISH} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     r, c;
    logic [N-1:0][31:0] src, dst;
    logic [IW-1:0]     src_idx, dst_idx;
    logic              last;

    assign last    = (r == R_LAST) && (c == C_LAST);
    assign src_idx = IW'(r * COLS + c);
    assign dst_idx = IW'(c * ROWS + r);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COPY;
            COPY:    if (last)  state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r    <= '0;
            c    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            A_T  <= '0;
            src  <= '0;
            dst  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src  <= A;
                        r    <= '0;
                        c    <= '0;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                COPY: begin
                    dst[dst_idx] <= src[src_idx];
                    // Counters park at zero after the last element instead of running past R-1.
                    if (last) begin
                        r <= '0;
                        c <= '0;
                    end else if (c == C_LAST) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                FINISH: begin
                    A_T  <= dst;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
